noc_traffic_gen: RTL

- Synthesisable, parametrised per-node traffic generator and checker for the LOCAL port of a mesh router.
- Injects single-flit packets at a configurable injection rate with a selectable destination pattern.
- Sinks packets ejected at the node and checks their header and payload.
- Replaces the fixed testbench injection-rate constant with a per-instance, runtime-controlled block usable in simulation and on FPGA.

---
 rtl/noc_traffic_gen_pkg.sv | 43 ++++
 rtl/noc_traffic_gen_lfsr.sv | 21 ++
 rtl/noc_traffic_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/noc_traffic_gen_pkg.sv
// Shared NoC definitions: router port ids, traffic-generator modes and the
// single-flit header layout (fields packed LSB first in units of CW bits).
package noc_traffic_gen_pkg;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    TG_UNIFORM   = 2'd0,
    TG_TRANSPOSE = 2'd1,
    TG_FIXED     = 2'd2,
    TG_OFF       = 2'd3
  } tg_mode_t;

  localparam int SEQ_W = 16;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Header field index; bit offset is index * CW
  localparam int HDR_DST_X = 0;
  localparam int HDR_DST_Y = 1;
  localparam int HDR_SRC_X = 2;
  localparam int HDR_SRC_Y = 3;

  function automatic int coord_w(input int mesh_side);
    return (mesh_side > 2) ? $clog2(mesh_side) : 1;
  endfunction

  function automatic int seq_off(input int cw);
    return 4 * cw;
  endfunction

  function automatic int payload_off(input int cw);
    return 4 * cw + SEQ_W;
  endfunction

endpackage

// File: rtl/noc_traffic_gen_lfsr.sv
// 16-bit Galois LFSR; loads SEED in reset and steps only when adv is high.
module noc_lfsr16
  import noc_traffic_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (adv) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node traffic generator and ejection checker for a mesh router LOCAL port.
// state | meaning
// IDLE  | waiting for en with a mode other than OFF
// GEN   | drawing one injection decision per cycle
// HOLD  | flit presented, waiting for out_ready
// DONE  | MAX_PACKETS sent, sticky until rst
module noc_traffic_gen
  import noc_traffic_gen_pkg::*;
#(
  parameter int          DATA_WIDTH  = 512,
  parameter int          MESH_SIDE   = 4,
  parameter int          X_POS       = 0,
  parameter int          Y_POS       = 0,
  parameter int          INJ_PERCENT = 100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_PACKETS = 1024,
  localparam int         CW          = coord_w(MESH_SIDE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  tg_mode_t              mode,
  input  logic [CW-1:0]         fixed_dst_x,
  input  logic [CW-1:0]         fixed_dst_y,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [31:0]           tx_count,
  output logic [31:0]           rx_count,
  output logic [31:0]           err_count,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int SEQ_OFF = seq_off(CW);
  localparam int PAY_OFF = payload_off(CW);
  localparam int PAY_W   = DATA_WIDTH - PAY_OFF;

  localparam logic [CW-1:0] OWN_X     = CW'(X_POS);
  localparam logic [CW-1:0] OWN_Y     = CW'(Y_POS);
  localparam logic          HAS_LIMIT = (MAX_PACKETS != 0);

  logic [1:0]    state;
  logic [15:0]   lfsr;
  logic [15:0]   seq;
  logic [6:0]    draw_p;
  logic          draw_hit;
  logic [CW-1:0] dst_x;
  logic [CW-1:0] dst_y;
  logic          dst_ok;
  logic [15:0]   rx_seq;
  logic          rx_err;

  function automatic logic [PAY_W-1:0] payload_of(input logic [15:0] s);
    logic [31:0]      pat;
    logic [PAY_W-1:0] p;
    pat = {s, ~s};
    p   = '0;
    for (int i = 0; i < PAY_W; i++) p[i] = pat[i[4:0]];
    return p;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  noc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (state == S_GEN),
    .value (lfsr)
  );

  // p = floor(lfsr*100 / 2^16) lies in 0..99
  assign draw_p   = 7'((32'(lfsr) * 32'd100) >> 16);
  assign draw_hit = (draw_p < 7'(INJ_PERCENT));

  always_comb begin
    dst_x  = OWN_X;
    dst_y  = OWN_Y;
    dst_ok = 1'b0;
    case (mode)
      TG_UNIFORM: begin
        dst_x  = CW'(32'(lfsr[8 +: CW]) % MESH_SIDE);
        dst_y  = CW'(32'(lfsr[12 +: CW]) % MESH_SIDE);
        dst_ok = 1'b1;
      end
      TG_TRANSPOSE: begin
        dst_x  = OWN_Y;
        dst_y  = OWN_X;
        dst_ok = 1'b1;
      end
      TG_FIXED: begin
        dst_x  = fixed_dst_x;
        dst_y  = fixed_dst_y;
        dst_ok = 1'b1;
      end
      default: ;
    endcase
    if (dst_x == OWN_X && dst_y == OWN_Y) dst_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      seq       <= '0;
      tx_count  <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (en && mode != TG_OFF) state <= S_GEN;
        S_GEN: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (draw_hit && dst_ok) begin
            out_data  <= {payload_of(seq), seq, OWN_Y, OWN_X, dst_y, dst_x};
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            seq       <= seq + 16'd1;
            tx_count  <= sat_inc(tx_count);
            if (HAS_LIMIT && (tx_count + 32'd1 == 32'(MAX_PACKETS))) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_GEN;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end
      endcase
    end
  end

  // A flit is bad if misrouted, claims to come from this node, or has a corrupt payload
  assign rx_seq = in_data[SEQ_OFF +: 16];
  assign rx_err = (in_data[HDR_DST_X*CW +: CW] != OWN_X)
               || (in_data[HDR_DST_Y*CW +: CW] != OWN_Y)
               || ((in_data[HDR_SRC_X*CW +: CW] == OWN_X) && (in_data[HDR_SRC_Y*CW +: CW] == OWN_Y))
               || (in_data[DATA_WIDTH-1:PAY_OFF] != payload_of(rx_seq));

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      in_ready <= 1'b1;
      if (in_valid) begin
        rx_count <= sat_inc(rx_count);
        if (rx_err) err_count <= sat_inc(err_count);
      end
    end
  end

endmodule
